// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a registered-read sync FIFO onto a valid/ready stream
// through a small circular skid buffer that hides the one-cycle read latency.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd_en,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]  o_word_cnt,
  output logic                  o_busy
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam logic [PW-1:0] LAST  = PW'(BUF_DEPTH - 1);
  localparam logic [OW:0]   DEPTH = (OW + 1)'(BUF_DEPTH);
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0] head, tail;
  logic [OW-1:0] occ;
  logic [OW:0]   level;
  logic          inflight, pop;
  assign o_valid = occ != '0;
  assign o_busy  = o_valid | inflight;
  assign o_data  = o_valid ? mem[head] : '0;
  // Counting this cycle's pop lets a full buffer refill while draining at one word per cycle.
  always_comb begin
    pop          = o_valid & i_ready;
    level        = {1'b0, occ} + (OW + 1)'(inflight) - (OW + 1)'(pop);
    o_fifo_rd_en = !i_rst & i_enable & !i_fifo_empty & (level < DEPTH);
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      occ        <= '0;
      inflight   <= 1'b0;
      head       <= '0;
      tail       <= '0;
      o_word_cnt <= '0;
    end else begin
      inflight <= o_fifo_rd_en;
      occ      <= occ + OW'(inflight) - OW'(pop);
      if (inflight) tail <= (tail == LAST) ? '0 : tail + PW'(1);
      if (pop) begin
        head       <= (head == LAST) ? '0 : head + PW'(1);
        o_word_cnt <= o_word_cnt + CNT_WIDTH'(1);
      end
    end
  always_ff @(posedge i_clk)
    if (inflight) mem[tail] <= i_fifo_data;
  a_occ_bound: assert property (@(posedge i_clk) disable iff (i_rst) {1'b0, occ} <= DEPTH);
endmodule
